// File: rtl/vend_pkg.sv
// Shared types for the coin credit block: coin encodings, value table, state enum.
package vend_pkg;

  localparam int CREDIT_W_DEF = 8;

  typedef enum logic [1:0] {
    COIN_5   = 2'b00,
    COIN_10  = 2'b01,
    COIN_25  = 2'b10,
    COIN_100 = 2'b11
  } coin_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_PAYOUT
  } cc_state_e;

  function automatic int coin_value(coin_code_e c);
    int v;
    v = 0;
    unique case (c)
      COIN_5:   v = 5;
      COIN_10:  v = 10;
      COIN_25:  v = 25;
      COIN_100: v = 100;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_value_lut.sv
// Combinational coin_code to credit value lookup.
module coin_value_lut
  import vend_pkg::*;
#(
  parameter int CREDIT_W = CREDIT_W_DEF
) (
  input  logic [1:0]          coin_code,
  output logic [CREDIT_W-1:0] value
);

  assign value = CREDIT_W'(coin_value(coin_code_e'(coin_code)));

endmodule

// File: rtl/coin_credit.sv
// Coin credit accumulator with refund and vend settlement.
// COIN_CREDIT_CHANGE_RETURN_EN: pay out vend remainder instead of keeping it.
module coin_credit
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = CREDIT_W_DEF,
  parameter int MAX_CREDIT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic [CREDIT_W-1:0] price,
  input  logic                vend,
  input  logic                cancel,
  output logic                coin,
  output logic                sufficient,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid,
  output logic                reject
);

  cc_state_e           state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                cv_q, cv_d;
  logic                coin_q, coin_d;
  logic                rej_q, rej_d;
  logic                suff_q, suff_d;

  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] remain;
  logic                cancel_ok;
  logic                vend_ok;
  logic                coin_ok;

  coin_value_lut #(.CREDIT_W(CREDIT_W)) u_lut (
    .coin_code (coin_code),
    .value     (coin_val)
  );

  // Sum is one bit wider so an overflowing coin is refused, not wrapped.
  assign sum       = {1'b0, credit_q} + {1'b0, coin_val};
  assign remain    = credit_q - price;
  assign cancel_ok = cancel && (state_q == ST_CREDIT);
  assign vend_ok   = vend && suff_q && (state_q == ST_CREDIT);
  assign coin_ok   = !cancel && !vend
                  && (state_q != ST_PAYOUT)
                  && (sum <= (CREDIT_W+1)'(MAX_CREDIT));

  always_comb begin
    state_d  = (state_q == ST_PAYOUT) ? ST_IDLE : state_q;
    credit_d = credit_q;
    change_d = '0;
    cv_d     = 1'b0;
    coin_d   = 1'b0;
    rej_d    = 1'b0;
    if (cancel_ok) begin
      change_d = credit_q;
      cv_d     = 1'b1;
      credit_d = '0;
      state_d  = ST_PAYOUT;
    end else if (vend_ok) begin
`ifdef COIN_CREDIT_CHANGE_RETURN_EN
      credit_d = '0;
      if (remain != '0) begin
        change_d = remain;
        cv_d     = 1'b1;
        state_d  = ST_PAYOUT;
      end else begin
        state_d  = ST_IDLE;
      end
`else
      credit_d = remain;
      state_d  = (remain == '0) ? ST_IDLE : ST_CREDIT;
`endif
    end
    if (coin_valid) begin
      if (coin_ok) begin
        credit_d = sum[CREDIT_W-1:0];
        coin_d   = 1'b1;
        state_d  = ST_CREDIT;
      end else begin
        rej_d    = 1'b1;
      end
    end
    suff_d = (credit_d >= price);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      change_q <= '0;
      cv_q     <= 1'b0;
      coin_q   <= 1'b0;
      rej_q    <= 1'b0;
      suff_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      cv_q     <= cv_d;
      coin_q   <= coin_d;
      rej_q    <= rej_d;
      suff_q   <= suff_d;
    end
  end

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    vend_ok |-> (credit_q >= price)
  );

  assign coin         = coin_q;
  assign sufficient   = suff_q;
  assign credit       = credit_q;
  assign change       = change_q;
  assign change_valid = cv_q;
  assign reject       = rej_q;

endmodule

// File: tb/tb_coin_credit.sv
// Scoreboard bench for coin_credit: driver queues expectations, monitor compares.
module tb_coin_credit;

  typedef struct packed {
    logic       coin;
    logic       suff;
    logic [7:0] credit;
    logic [7:0] change;
    logic       cv;
    logic       rej;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic [7:0] price;
  logic       vend;
  logic       cancel;
  logic       coin;
  logic       sufficient;
  logic [7:0] credit;
  logic [7:0] change;
  logic       change_valid;
  logic       reject;

  exp_t exp_q[$];
  int   n_pass;
  int   n_total;
  bit   done;

  coin_credit #(.CREDIT_W(8), .MAX_CREDIT(255)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_valid   (coin_valid),
    .coin_code    (coin_code),
    .price        (price),
    .vend         (vend),
    .cancel       (cancel),
    .coin         (coin),
    .sufficient   (sufficient),
    .credit       (credit),
    .change       (change),
    .change_valid (change_valid),
    .reject       (reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int got, int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s got=%0d want=%0d", nm, got, want);
  endtask

  // Monitor: every falling edge with a pending expectation is one response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("coin",   coin,         e.coin);
        chk("suff",   sufficient,   e.suff);
        chk("credit", credit,       e.credit);
        chk("change", change,       e.change);
        chk("cv",     change_valid, e.cv);
        chk("reject", reject,       e.rej);
      end
    end
  end

  task automatic step(
    input logic       cv_i,
    input logic [1:0] code_i,
    input logic [7:0] price_i,
    input logic       vend_i,
    input logic       cancel_i,
    input logic       e_coin,
    input logic       e_suff,
    input int         e_credit,
    input int         e_change,
    input logic       e_cv,
    input logic       e_rej
  );
    exp_t e;
    coin_valid = cv_i;
    coin_code  = code_i;
    price      = price_i;
    vend       = vend_i;
    cancel     = cancel_i;
    e.coin   = e_coin;
    e.suff   = e_suff;
    e.credit = 8'(e_credit);
    e.change = 8'(e_change);
    e.cv     = e_cv;
    e.rej    = e_rej;
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    coin_valid = 1'b0;
    vend       = 1'b0;
    cancel     = 1'b0;
  endtask

  task automatic do_reset(input logic [7:0] p);
    price = p;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    done = 1'b0;
    coin_valid = 1'b0;
    coin_code = 2'b00;
    vend = 1'b0;
    cancel = 1'b0;
    price = 8'd0;
    rst_n = 1'b0;
    #2;
    // Reset state, including sufficient low with price 0.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_credit", credit, 0);
    chk("rst_suff", sufficient, 0);
    chk("rst_cv", change_valid, 0);
    chk("rst_coin", coin, 0);
    chk("rst_rej", reject, 0);
    chk("rst_change", change, 0);

    // Two coins then vend at price 30.
    do_reset(8'd30);
    //   cv code   price  vd cn  coin suf cred chg cv rej
    step(0, 2'b00, 8'd30, 0, 0,  0,   0,  0,   0,  0, 0);
    step(1, 2'b10, 8'd30, 0, 0,  1,   0,  25,  0,  0, 0);
    step(1, 2'b01, 8'd30, 0, 0,  1,   1,  35,  0,  0, 0);
`ifdef COIN_CREDIT_CHANGE_RETURN_EN
    step(0, 2'b00, 8'd30, 1, 0,  0,   0,  0,   5,  1, 0);
    step(0, 2'b00, 8'd30, 0, 0,  0,   0,  0,   0,  0, 0);
`else
    step(0, 2'b00, 8'd30, 1, 0,  0,   0,  5,   0,  0, 0);
    step(0, 2'b00, 8'd30, 0, 0,  0,   0,  5,   0,  0, 0);
`endif

    // Overflow refusal and exact MAX_CREDIT boundary.
    do_reset(8'd255);
    step(1, 2'b11, 8'd255, 0, 0, 1,   0,  100, 0,  0, 0);
    step(1, 2'b11, 8'd255, 0, 0, 1,   0,  200, 0,  0, 0);
    step(1, 2'b11, 8'd255, 0, 0, 0,   0,  200, 0,  0, 1);
    step(0, 2'b00, 8'd255, 0, 0, 0,   0,  200, 0,  0, 0);
    step(1, 2'b10, 8'd255, 0, 0, 1,   0,  225, 0,  0, 0);
    step(1, 2'b10, 8'd255, 0, 0, 1,   0,  250, 0,  0, 0);
    step(1, 2'b00, 8'd255, 0, 0, 1,   1,  255, 0,  0, 0);
    step(1, 2'b00, 8'd255, 0, 0, 0,   1,  255, 0,  0, 1);

    // Cancel + vend + coin together, then coin in PAYOUT, cancel in IDLE.
    do_reset(8'd30);
    step(1, 2'b10, 8'd30, 0, 0,  1,   0,  25,  0,  0, 0);
    step(1, 2'b01, 8'd30, 0, 0,  1,   1,  35,  0,  0, 0);
    step(1, 2'b00, 8'd30, 0, 0,  1,   1,  40,  0,  0, 0);
    step(1, 2'b00, 8'd30, 1, 1,  0,   0,  0,   40, 1, 1);
    step(1, 2'b01, 8'd30, 0, 0,  0,   0,  0,   0,  0, 1);
    step(0, 2'b00, 8'd30, 0, 1,  0,   0,  0,   0,  0, 0);

    // Price rises past credit; vend ignored; exact-price vend clears.
    do_reset(8'd30);
    step(1, 2'b10, 8'd30, 0, 0,  1,   0,  25,  0,  0, 0);
    step(1, 2'b10, 8'd30, 0, 0,  1,   1,  50,  0,  0, 0);
    step(0, 2'b00, 8'd60, 0, 0,  0,   0,  50,  0,  0, 0);
    step(0, 2'b00, 8'd60, 1, 0,  0,   0,  50,  0,  0, 0);
    step(0, 2'b00, 8'd50, 0, 0,  0,   1,  50,  0,  0, 0);
    step(0, 2'b00, 8'd50, 1, 0,  0,   0,  0,   0,  0, 0);

    // Asynchronous reset mid-cycle with credit held.
    do_reset(8'd100);
    step(1, 2'b10, 8'd100, 0, 0, 1,   0,  25,  0,  0, 0);
    step(1, 2'b10, 8'd100, 0, 0, 1,   0,  50,  0,  0, 0);
    step(1, 2'b01, 8'd100, 0, 0, 1,   0,  60,  0,  0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_credit", credit, 0);
    chk("async_coin", coin, 0);
    chk("async_cv", change_valid, 0);
    chk("async_change", change, 0);
    @(posedge clk);
    #1;
    chk("async_cv_hold", change_valid, 0);
    chk("async_credit_hold", credit, 0);
    rst_n = 1'b1;

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL queue_drain got=%0d want=0", exp_q.size());
    end
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
    end
  end

endmodule

// File: doc/coin_credit.md
COIN_CREDIT -- requirements
Module: coin_credit

Interface
REQ-001 Parameter CREDIT_W, default 8, width of credit, price and change buses.
REQ-002 Parameter MAX_CREDIT, default 255, highest credit value the block accepts.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 coin_valid  input  1  one-cycle strobe: a coin is present on coin_code.
REQ-006 coin_code  input  2  coin denomination: 00=5, 01=10, 10=25, 11=100.
REQ-007 price  input  CREDIT_W  price of the selected product; may change at any time.
REQ-008 vend  input  1  one-cycle strobe from the downstream vend FSM in its dispense state.
REQ-009 cancel  input  1  one-cycle strobe: customer requests a refund.
REQ-010 coin  output  1  one-cycle pulse: a coin was accepted; feeds the vend FSM coin input.
REQ-011 sufficient  output  1  registered flag, credit >= price; feeds the vend FSM sufficient input.
REQ-012 credit  output  CREDIT_W  current accumulated credit.
REQ-013 change  output  CREDIT_W  payout amount; valid only while change_valid is high.
REQ-014 change_valid  output  1  one-cycle payout strobe.
REQ-015 reject  output  1  one-cycle pulse: the coin on coin_valid was refused.

Function
REQ-016 States are IDLE (credit==0), CREDIT (credit>0) and PAYOUT (single cycle).
- IDLE->CREDIT on an accepted coin.
- CREDIT->PAYOUT on cancel, or on vend with nonzero change.
- CREDIT->IDLE when credit reaches 0.
- PAYOUT->IDLE unconditionally after one cycle.
REQ-017 Accepted coin: credit <= credit + value one cycle after coin_valid; coin pulses high in that same cycle.
REQ-018 If credit + value > MAX_CREDIT, the coin is refused: reject pulses one cycle after coin_valid and credit is unchanged.
- The sum is computed at CREDIT_W+1 bits, so no wrap-around.
REQ-019 sufficient is a registered output equal to (credit_next >= price_sampled); it tracks price changes with one-cycle latency.
REQ-020 vend is honoured only while sufficient=1: credit <= credit - price.
- vend with sufficient=0 is ignored; no output changes.
REQ-021 cancel in CREDIT: change <= credit, change_valid pulses one cycle, credit <= 0.
- cancel in IDLE or PAYOUT is ignored.
REQ-022 Priority for simultaneous events: cancel > vend > coin.
- A coin_valid coinciding with cancel or vend is refused with reject.
REQ-023 coin_valid during PAYOUT is refused with reject.
REQ-024 The subtraction credit - price is never negative. This is guaranteed by REQ-020; a violation is an assertion failure.

Reset
REQ-025 While rst_n=0: state=IDLE, credit=0, change=0, and coin, sufficient, change_valid, reject are all 0.
- sufficient stays 0 at reset even if price=0.
REQ-026 Reset asserted mid-operation discards all credit immediately, without a payout strobe.

Configuration
REQ-027 Macro COIN_CREDIT_CHANGE_RETURN_EN selects how leftover credit after a vend is handled.
- Defined: after a vend the remainder credit - price is paid out via change/change_valid in the following cycle (PAYOUT), and credit becomes 0.
- Undefined: the remainder is retained as credit for a further purchase, and vend never produces change_valid.

Structure
REQ-028 Package vend_pkg holds:
- the coin_code encodings and the coin value table;
- the coin_credit state enum;
- the CREDIT_W default.
REQ-029 One sub-module, coin_value_lut, maps coin_code to a CREDIT_W-bit value (purely combinational). All other logic lives in coin_credit.

Verification
REQ-030 Reset, price=30, coins 25 then 10 -> credit 25 then 35; coin pulses twice; sufficient goes 0 then 1.
REQ-031 credit=35, price=30, vend -> with macro: change=5, change_valid one cycle, credit=0, state IDLE; without macro: credit=5, no change_valid.
REQ-032 credit=200, coin 100 -> reject one cycle, credit stays 200, no coin pulse.
REQ-033 credit=40, cancel and vend asserted together -> change=40 with change_valid, credit=0, vend ignored.
REQ-034 credit=50, price changes 30->60 -> sufficient falls 1 cycle later; a subsequent vend is ignored with credit still 50.
REQ-035 credit=60, rst_n pulsed low mid-cycle -> all outputs 0 asynchronously, no change_valid.
